// File: rtl/atm_cash_dispenser.sv
// Note dispenser behind the ATM controller: plans a greedy 500/200/100 split of an
// approved amount against cassette stock, then releases the notes one pulse at a time.
module atm_cash_dispenser #(
    parameter int AMT_W     = 21,
    parameter int CNT_W     = 8,
    parameter int NOTE_GAP  = 4,
    parameter int MAX_NOTES = 40,
    parameter int INIT_500  = 50,
    parameter int INIT_200  = 50,
    parameter int INIT_100  = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             txn_success,
    input  logic [AMT_W-1:0] amount_withdraw,
    input  logic             refill,
    output logic             dispense_500,
    output logic             dispense_200,
    output logic             dispense_100,
    output logic             busy,
    output logic             done,
    output logic             dispense_err,
    output logic [CNT_W-1:0] cnt_500,
    output logic [CNT_W-1:0] cnt_200,
    output logic [CNT_W-1:0] cnt_100
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_PLAN     = 3'd2;
    localparam logic [2:0] S_DISPENSE = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam int GAP_W = (NOTE_GAP > 1) ? $clog2(NOTE_GAP) : 1;
    localparam int TOT_W = CNT_W + 2;

    logic [2:0]       state_reg, state_next;
    logic [AMT_W-1:0] rem_reg, rem_next;
    logic [GAP_W-1:0] gap_reg, gap_next;

    // Index 0/1/2 = 500/200/100 cassette, which is also the greedy priority order.
    logic [CNT_W-1:0] cnt_cur  [3];
    logic [CNT_W-1:0] plan_cur [3];
    logic [2:0]       pulse_cur;
    logic [2:0]       can_take;
    logic [2:0]       has_notes;
    logic [2:0]       plan_inc;
    logic [2:0]       disp_fire;
    logic [TOT_W-1:0] note_total;
    logic             idle_start;
    logic             idle_refill;

    assign idle_start  = (state_reg == S_IDLE) && txn_success;
    assign idle_refill = (state_reg == S_IDLE) && refill;
    assign note_total  = TOT_W'(plan_cur[0]) + TOT_W'(plan_cur[1]) + TOT_W'(plan_cur[2]);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cassette
            localparam logic [AMT_W-1:0] DENOM = (gi == 0) ? AMT_W'(500) :
                                                 (gi == 1) ? AMT_W'(200) : AMT_W'(100);
            localparam logic [CNT_W-1:0] LOAD  = (gi == 0) ? CNT_W'(INIT_500) :
                                                 (gi == 1) ? CNT_W'(INIT_200) : CNT_W'(INIT_100);

            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] plan_reg;
            logic             pulse_reg;

            // Planned notes never exceed stock, so the decrement cannot wrap.
            assign can_take[gi]  = (rem_reg >= DENOM) && (plan_reg < cnt_reg);
            assign has_notes[gi] = (plan_reg != '0);
            assign cnt_cur[gi]   = cnt_reg;
            assign plan_cur[gi]  = plan_reg;
            assign pulse_cur[gi] = pulse_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg   <= LOAD;
                    plan_reg  <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= disp_fire[gi];
                    if (idle_refill) begin
                        cnt_reg <= LOAD;
                    end else if (disp_fire[gi]) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                    if (idle_start) begin
                        plan_reg <= '0;
                    end else if (plan_inc[gi]) begin
                        plan_reg <= plan_reg + CNT_W'(1);
                    end else if (disp_fire[gi]) begin
                        plan_reg <= plan_reg - CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        gap_next   = gap_reg;
        plan_inc   = '0;
        disp_fire  = '0;
        case (state_reg)
            S_IDLE: begin
                if (txn_success) begin
                    rem_next   = amount_withdraw;
                    gap_next   = '0;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((rem_reg == '0) || ((rem_reg % AMT_W'(100)) != '0)) begin
                    state_next = S_ERR;
                end else begin
                    state_next = S_PLAN;
                end
            end
            S_PLAN: begin
                // Another note is still wanted; refuse if the plan is already full.
                if (can_take != '0) begin
                    if (note_total >= TOT_W'(MAX_NOTES)) begin
                        state_next = S_ERR;
                    end else if (can_take[0]) begin
                        plan_inc = 3'b001;
                        rem_next = rem_reg - AMT_W'(500);
                    end else if (can_take[1]) begin
                        plan_inc = 3'b010;
                        rem_next = rem_reg - AMT_W'(200);
                    end else begin
                        plan_inc = 3'b100;
                        rem_next = rem_reg - AMT_W'(100);
                    end
                end else if (rem_reg == '0) begin
                    gap_next   = '0;
                    state_next = S_DISPENSE;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_DISPENSE: begin
                if (has_notes == '0) begin
                    state_next = S_DONE;
                end else if (gap_reg == '0) begin
                    gap_next = GAP_W'(NOTE_GAP - 1);
                    if (has_notes[0]) begin
                        disp_fire = 3'b001;
                    end else if (has_notes[1]) begin
                        disp_fire = 3'b010;
                    end else begin
                        disp_fire = 3'b100;
                    end
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            rem_reg   <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            gap_reg   <= gap_next;
        end
    end

    assign dispense_500 = pulse_cur[0];
    assign dispense_200 = pulse_cur[1];
    assign dispense_100 = pulse_cur[2];
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);
    assign dispense_err = (state_reg == S_ERR);
    assign cnt_500      = cnt_cur[0];
    assign cnt_200      = cnt_cur[1];
    assign cnt_100      = cnt_cur[2];

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Bench for atm_cash_dispenser: table of withdrawals with hand-computed note splits
// and cassette levels, plus busy-drop and mid-dispense reset sequences.
module tb_atm_cash_dispenser;
    localparam int AMT_W = 21;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             a_reset, a_txn, a_refill, b_reset, b_txn, b_refill;
    logic [AMT_W-1:0] a_amt, b_amt;
    logic             a_d5, a_d2, a_d1, a_busy, a_done, a_err;
    logic             b_d5, b_d2, b_d1, b_busy, b_done, b_err;
    logic [CNT_W-1:0] a_c5, a_c2, a_c1, b_c5, b_c2, b_c1;

    atm_cash_dispenser dut_a (
        .clk(clk), .reset(a_reset), .txn_success(a_txn), .amount_withdraw(a_amt),
        .refill(a_refill), .dispense_500(a_d5), .dispense_200(a_d2), .dispense_100(a_d1),
        .busy(a_busy), .done(a_done), .dispense_err(a_err),
        .cnt_500(a_c5), .cnt_200(a_c2), .cnt_100(a_c1)
    );

    atm_cash_dispenser #(.INIT_500(1), .MAX_NOTES(4)) dut_b (
        .clk(clk), .reset(b_reset), .txn_success(b_txn), .amount_withdraw(b_amt),
        .refill(b_refill), .dispense_500(b_d5), .dispense_200(b_d2), .dispense_100(b_d1),
        .busy(b_busy), .done(b_done), .dispense_err(b_err),
        .cnt_500(b_c5), .cnt_200(b_c2), .cnt_100(b_c1)
    );

    logic             sel;
    logic             o_d5, o_d2, o_d1, o_busy, o_done, o_err;
    logic [CNT_W-1:0] o_c5, o_c2, o_c1;
    assign o_d5   = sel ? b_d5   : a_d5;
    assign o_d2   = sel ? b_d2   : a_d2;
    assign o_d1   = sel ? b_d1   : a_d1;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_err  = sel ? b_err  : a_err;
    assign o_c5   = sel ? b_c5   : a_c5;
    assign o_c2   = sel ? b_c2   : a_c2;
    assign o_c1   = sel ? b_c1   : a_c1;

    typedef struct {
        bit               dut;
        logic [AMT_W-1:0] amt;
        bit               rf;
        int               e5, e2, e1;
        bit               eerr;
        int               c5, c2, c1;
    } vec_t;

    vec_t vecs [15];
    int   checks = 0;
    int   errors = 0;
    int   n5, n2, n1, ndone, nerr, gap_bad, multi, order_bad, last_cyc, last_den;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic txn, input logic rf, input logic [AMT_W-1:0] amt);
        if (sel) begin
            b_txn = txn; b_refill = rf; b_amt = amt;
        end else begin
            a_txn = txn; a_refill = rf; a_amt = amt;
        end
    endtask

    task automatic observe(input int cyc);
        int den;
        if (int'(o_d5) + int'(o_d2) + int'(o_d1) > 1) multi++;
        if (o_d5 || o_d2 || o_d1) begin
            den = o_d5 ? 500 : (o_d2 ? 200 : 100);
            if (last_cyc >= 0 && cyc - last_cyc != 4) gap_bad++;
            if (last_den >= 0 && den > last_den) order_bad++;
            last_cyc = cyc;
            last_den = den;
        end
        n5    += int'(o_d5);
        n2    += int'(o_d2);
        n1    += int'(o_d1);
        ndone += int'(o_done);
        nerr  += int'(o_err);
    endtask

    // Follows one transaction to its done/err pulse, then steps into IDLE.
    task automatic wait_end(input string tag);
        bit fin;
        fin = 1'b0;
        n5 = 0; n2 = 0; n1 = 0; ndone = 0; nerr = 0;
        gap_bad = 0; multi = 0; order_bad = 0; last_cyc = -1; last_den = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            observe(cyc);
            if (o_done || o_err) begin
                fin = 1'b1;
                break;
            end
            tick();
        end
        check({tag, " finished"}, int'(fin), 1);
        tick();
        observe(999);
        check({tag, " busy after"}, int'(o_busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 21'd500,   1'b0, 1,  0, 1, 1'b0, 49, 50, 50};
        vecs[0].e1 = 0;
        vecs[1]  = '{1'b0, 21'd800,   1'b1, 1,  1, 1, 1'b0, 49, 49, 49};
        vecs[2]  = '{1'b0, 21'd250,   1'b0, 0,  0, 0, 1'b1, 49, 49, 49};
        vecs[3]  = '{1'b0, 21'd0,     1'b0, 0,  0, 0, 1'b1, 49, 49, 49};
        vecs[4]  = '{1'b0, 21'd600,   1'b0, 1,  0, 1, 1'b0, 48, 49, 48};
        vecs[5]  = '{1'b0, 21'd2300,  1'b0, 4,  1, 1, 1'b0, 44, 48, 47};
        vecs[6]  = '{1'b0, 21'd4000,  1'b0, 8,  0, 0, 1'b0, 36, 48, 47};
        vecs[7]  = '{1'b0, 21'd20000, 1'b0, 0,  0, 0, 1'b1, 36, 48, 47};
        vecs[8]  = '{1'b0, 21'd20000, 1'b1, 40, 0, 0, 1'b0, 10, 50, 50};
        vecs[9]  = '{1'b0, 21'd20100, 1'b1, 0,  0, 0, 1'b1, 50, 50, 50};
        vecs[10] = '{1'b0, 21'd150,   1'b0, 0,  0, 0, 1'b1, 50, 50, 50};
        vecs[11] = '{1'b0, 21'd100,   1'b0, 0,  0, 1, 1'b0, 50, 50, 49};
        vecs[12] = '{1'b1, 21'd500,   1'b0, 1,  0, 0, 1'b0, 0,  50, 50};
        vecs[13] = '{1'b1, 21'd500,   1'b0, 0,  2, 1, 1'b0, 0,  48, 49};
        vecs[14] = '{1'b1, 21'd5000,  1'b0, 0,  0, 0, 1'b1, 0,  48, 49};

        sel = 1'b0;
        a_txn = 1'b0; a_refill = 1'b0; a_amt = '0; a_reset = 1'b1;
        b_txn = 1'b0; b_refill = 1'b0; b_amt = '0; b_reset = 1'b1;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        check("reset busy", int'(a_busy), 0);
        check("reset done", int'(a_done), 0);
        check("reset err", int'(a_err), 0);
        check("reset pulses", int'(a_d5) + int'(a_d2) + int'(a_d1), 0);
        check("reset cnt_500", int'(a_c5), 50);
        check("reset cnt_200", int'(a_c2), 50);
        check("reset cnt_100", int'(a_c1), 50);
        check("reset b cnt_500", int'(b_c5), 1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            sel = vecs[i].dut;
            drive(1'b1, vecs[i].rf, vecs[i].amt);
            tick();
            drive(1'b0, 1'b0, '0);
            wait_end(tag);
            $display("txn %0d dut=%0d amt=%0d notes=%0d/%0d/%0d done=%0d err=%0d cnt=%0d/%0d/%0d",
                     i, sel, vecs[i].amt, n5, n2, n1, ndone, nerr, o_c5, o_c2, o_c1);
            check({tag, " n500"}, n5, vecs[i].e5);
            check({tag, " n200"}, n2, vecs[i].e2);
            check({tag, " n100"}, n1, vecs[i].e1);
            check({tag, " done"}, ndone, vecs[i].eerr ? 0 : 1);
            check({tag, " err"}, nerr, vecs[i].eerr ? 1 : 0);
            check({tag, " cnt_500"}, int'(o_c5), vecs[i].c5);
            check({tag, " cnt_200"}, int'(o_c2), vecs[i].c2);
            check({tag, " cnt_100"}, int'(o_c1), vecs[i].c1);
            check({tag, " gap"}, gap_bad, 0);
            check({tag, " onehot"}, multi, 0);
            check({tag, " order"}, order_bad, 0);
        end

        // txn_success and refill raised while planning must both be dropped.
        sel = 1'b0;
        drive(1'b1, 1'b0, 21'd800);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        drive(1'b1, 1'b1, 21'd500);
        tick();
        drive(1'b0, 1'b0, '0);
        wait_end("busy");
        $display("txn busy-drop amt=800 notes=%0d/%0d/%0d done=%0d cnt=%0d/%0d/%0d",
                 n5, n2, n1, ndone, o_c5, o_c2, o_c1);
        check("busy n500", n5, 1);
        check("busy n200", n2, 1);
        check("busy n100", n1, 1);
        check("busy done", ndone, 1);
        check("busy cnt_500", int'(o_c5), 49);
        check("busy cnt_200", int'(o_c2), 49);
        check("busy cnt_100", int'(o_c1), 48);
        begin
            int busy_seen;
            busy_seen = 0;
            for (int c = 0; c < 6; c++) begin
                busy_seen += int'(o_busy);
                tick();
            end
            check("busy dropped txn", busy_seen, 0);
        end

        drive(1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        $display("txn refill cnt=%0d/%0d/%0d", o_c5, o_c2, o_c1);
        check("refill cnt_500", int'(o_c5), 50);
        check("refill cnt_200", int'(o_c2), 50);
        check("refill cnt_100", int'(o_c1), 50);

        // Reset between the second and third note of an 800 withdrawal.
        begin
            int npulse;
            int late;
            npulse = 0;
            late = 0;
            drive(1'b1, 1'b0, 21'd800);
            tick();
            drive(1'b0, 1'b0, '0);
            for (int c = 0; c < 100 && npulse < 2; c++) begin
                tick();
                if (o_d5 || o_d2 || o_d1) npulse++;
            end
            check("rst notes before", npulse, 2);
            tick();
            tick();
            a_reset = 1'b1;
            tick();
            a_reset = 1'b0;
            $display("txn reset-abort amt=800 busy=%0d cnt=%0d/%0d/%0d", o_busy, o_c5, o_c2, o_c1);
            check("rst busy", int'(o_busy), 0);
            check("rst cnt_500", int'(o_c5), 50);
            check("rst cnt_200", int'(o_c2), 50);
            check("rst cnt_100", int'(o_c1), 50);
            for (int c = 0; c < 20; c++) begin
                late += int'(o_d5) + int'(o_d2) + int'(o_d1) + int'(o_done) + int'(o_busy);
                tick();
            end
            check("rst no activity", late, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
